// File: rtl/instruction_rx_if.sv
// instruction_rx_if
// Bundles the operator inputs, the receiver status outputs and the
// instruction queue handshake of instruction_rx.
//   master : operator / servo command decoder side
//            (drives data_bit, confirm_bit, instr_ready)
//   slave  : instruction_rx side
//            (drives waiting_bit, bit_index, instr_valid, instr_data,
//             fill, parity_err, overflow)
interface instruction_rx_if #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
);
    localparam int IDX_W  = $clog2(WIDTH + 2);
    localparam int FILL_W = $clog2(DEPTH + 1);

    logic              data_bit;
    logic              confirm_bit;
    logic              waiting_bit;
    logic [IDX_W-1:0]  bit_index;
    logic              instr_valid;
    logic [WIDTH-1:0]  instr_data;
    logic              instr_ready;
    logic [FILL_W-1:0] fill;
    logic              parity_err;
    logic              overflow;

    modport master (
        output data_bit, confirm_bit, instr_ready,
        input  waiting_bit, bit_index, instr_valid, instr_data,
               fill, parity_err, overflow
    );

    modport slave (
        input  data_bit, confirm_bit, instr_ready,
        output waiting_bit, bit_index, instr_valid, instr_data,
               fill, parity_err, overflow
    );
endinterface

// File: rtl/instruction_rx.sv
// instruction_rx
// Serial instruction receiver: collects WIDTH bits (MSB first, plus an
// optional trailing even-parity bit) from a data/confirm pair, with a
// lockout window of SETTLE cycles after every accepted confirm. Completed
// words are pushed into a DEPTH-entry first-word-fall-through queue that
// the consumer drains with instr_valid/instr_ready.
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    instruction_rx_if.slave (operator inputs, status, queue handshake)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RELEASE  | wait for confirm_bit low so a held confirm counts only once
// WAIT     | waiting_bit=1, capture data_bit on confirm_bit high
// SETTLE   | inputs ignored for SETTLE cycles, bit shifted on last count
// CHECK    | one cycle: parity / overflow decision and queue push
module instruction_rx #(
    parameter int WIDTH     = 10,
    parameter int SETTLE    = 11,
    parameter int PARITY_EN = 1,
    parameter int DEPTH     = 4
) (
    input logic              clk,
    input logic              reset,
    instruction_rx_if.slave  bus
);
    localparam int FRAME  = WIDTH + PARITY_EN;
    localparam int IDX_W  = $clog2(WIDTH + 2);
    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [IDX_W-1:0]  FRAME_IDX = IDX_W'(FRAME);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SETTLE - 1);
    localparam logic [FILL_W-1:0] FULL      = FILL_W'(DEPTH);

    typedef enum logic [1:0] {
        S_RELEASE,
        S_WAIT,
        S_SETTLE,
        S_CHECK
    } state_t;

    state_t state, state_nx;

    logic              captured;
    logic [CNT_W-1:0]  settle_cnt;
    logic [FRAME-1:0]  shreg;
    logic [IDX_W-1:0]  bit_index;
    logic              parity_err;
    logic              overflow;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FILL_W-1:0] fill;
    logic [WIDTH-1:0]  last_data;

    logic              settle_done;
    logic              last_bit;
    logic              parity_bad;
    logic              full;
    logic              pop;
    logic              push;
    logic [WIDTH-1:0]  frame_data;

    assign settle_done = (state == S_SETTLE) && (settle_cnt == CNT_LAST);
    assign last_bit    = (bit_index == FRAME_IDX - IDX_W'(1));
    assign parity_bad  = (PARITY_EN != 0) && (^shreg);
    assign full        = (fill == FULL);
    assign pop         = (fill != '0) && bus.instr_ready;
    // A pop in the CHECK cycle frees the slot the push needs.
    assign push        = (state == S_CHECK) && !parity_bad && (!full || pop);
    assign frame_data  = shreg[FRAME-1 -: WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RELEASE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_RELEASE: if (!bus.confirm_bit) state_nx = S_WAIT;
            S_WAIT:    if (bus.confirm_bit)  state_nx = S_SETTLE;
            S_SETTLE:  if (settle_done)      state_nx = last_bit ? S_CHECK : S_RELEASE;
            S_CHECK:   state_nx = S_RELEASE;
            default:   state_nx = S_RELEASE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            captured   <= 1'b0;
            settle_cnt <= '0;
            shreg      <= '0;
            bit_index  <= '0;
            parity_err <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            overflow   <= 1'b0;
            case (state)
                S_WAIT: begin
                    if (bus.confirm_bit) begin
                        captured   <= bus.data_bit;
                        settle_cnt <= '0;
                    end
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt + CNT_W'(1);
                    if (settle_done) begin
                        shreg     <= {shreg[FRAME-2:0], captured};
                        bit_index <= bit_index + IDX_W'(1);
                    end
                end
                S_CHECK: begin
                    parity_err <= parity_bad;
                    overflow   <= !parity_bad && full && !pop;
                    shreg      <= '0;
                    bit_index  <= '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= frame_data;
        end
    end

    // last_data keeps the most recently popped word so instr_data holds
    // its last value once the queue runs empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fill      <= '0;
            last_data <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                last_data <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   fill <= fill + FILL_W'(1);
                2'b01:   fill <= fill - FILL_W'(1);
                default: ;
            endcase
        end
    end

    assign bus.waiting_bit = (state == S_WAIT);
    assign bus.bit_index   = bit_index;
    assign bus.instr_valid = (fill != '0);
    assign bus.instr_data  = (fill != '0) ? mem[rd_ptr] : last_data;
    assign bus.fill        = fill;
    assign bus.parity_err  = parity_err;
    assign bus.overflow    = overflow;
endmodule

// File: tb/tb_instruction_rx.sv
// tb_instruction_rx
// Two receivers side by side: dut0 without parity, dut1 with even parity
// (both WIDTH=10, SETTLE=11, DEPTH=4). A frame-level queue model predicts
// queue contents, fill and parity_err/overflow pulse counts.
module tb_instruction_rx;
    localparam int W  = 10;
    localparam int ST = 11;
    localparam int D  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst  [2] = '{1'b1, 1'b1};
    logic dbit [2] = '{1'b0, 1'b0};
    logic conf [2] = '{1'b0, 1'b0};
    logic rdy  [2] = '{1'b0, 1'b0};

    instruction_rx_if #(.WIDTH(W), .DEPTH(D)) if0 ();
    instruction_rx_if #(.WIDTH(W), .DEPTH(D)) if1 ();

    assign if0.data_bit    = dbit[0];
    assign if0.confirm_bit = conf[0];
    assign if0.instr_ready = rdy[0];
    assign if1.data_bit    = dbit[1];
    assign if1.confirm_bit = conf[1];
    assign if1.instr_ready = rdy[1];

    instruction_rx #(.WIDTH(W), .SETTLE(ST), .PARITY_EN(0), .DEPTH(D)) dut0 (
        .clk(clk), .reset(rst[0]), .bus(if0.slave));
    instruction_rx #(.WIDTH(W), .SETTLE(ST), .PARITY_EN(1), .DEPTH(D)) dut1 (
        .clk(clk), .reset(rst[1]), .bus(if1.slave));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int wviol = 0;

    int   perr_cnt  [2] = '{0, 0};
    int   ovf_cnt   [2] = '{0, 0};
    int   vrise_cyc [2] = '{0, 0};
    logic pv        [2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        if (if0.parity_err === 1'b1) perr_cnt[0]++;
        if (if0.overflow   === 1'b1) ovf_cnt[0]++;
        if (if1.parity_err === 1'b1) perr_cnt[1]++;
        if (if1.overflow   === 1'b1) ovf_cnt[1]++;
        if (if0.instr_valid === 1'b1 && pv[0] !== 1'b1) vrise_cyc[0] = cyc;
        if (if1.instr_valid === 1'b1 && pv[1] !== 1'b1) vrise_cyc[1] = cyc;
        pv[0] = if0.instr_valid;
        pv[1] = if1.instr_valid;
    end

    function automatic logic f_wait(int s);
        return (s == 0) ? if0.waiting_bit : if1.waiting_bit;
    endfunction
    function automatic logic f_valid(int s);
        return (s == 0) ? if0.instr_valid : if1.instr_valid;
    endfunction
    function automatic logic [W-1:0] f_data(int s);
        return (s == 0) ? if0.instr_data : if1.instr_data;
    endfunction
    function automatic logic [2:0] f_fill(int s);
        return (s == 0) ? if0.fill : if1.fill;
    endfunction
    function automatic logic [3:0] f_idx(int s);
        return (s == 0) ? if0.bit_index : if1.bit_index;
    endfunction

    // ---------------- reference model (frame level) ----------------
    logic [W-1:0] mq0 [$];
    logic [W-1:0] mq1 [$];
    int exp_perr [2] = '{0, 0};
    int exp_ovf  [2] = '{0, 0};

    function automatic int m_size(int s);
        return (s == 0) ? mq0.size() : mq1.size();
    endfunction
    function automatic logic [W-1:0] m_front(int s);
        if (s == 0) return (mq0.size() > 0) ? mq0[0] : '0;
        return (mq1.size() > 0) ? mq1[0] : '0;
    endfunction
    function automatic void m_pop(int s);
        if (s == 0 && mq0.size() > 0) mq0.delete(0);
        if (s == 1 && mq1.size() > 0) mq1.delete(0);
    endfunction
    function automatic void m_push(int s, logic [W-1:0] w);
        if (s == 0) mq0.push_back(w);
        else        mq1.push_back(w);
    endfunction
    // fr holds the frame as sent, MSB first: dut0 uses fr[9:0],
    // dut1 uses fr[10:1] as data and fr[0] as the parity bit.
    function automatic void m_frame(int s, logic [10:0] fr, bit pop_now);
        logic [W-1:0] w;
        bit bad;
        bit popped;
        int sz;
        w      = (s == 0) ? fr[9:0] : fr[10:1];
        bad    = (s == 1) && (^fr);
        sz     = m_size(s);
        popped = pop_now && (sz > 0);
        if (popped) m_pop(s);
        if (bad)                        exp_perr[s]++;
        else if (sz == D && !popped)    exp_ovf[s]++;
        else                            m_push(s, w);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic wait_waiting(int s);
        int n = 0;
        while (f_wait(s) !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (f_wait(s) !== 1'b1) begin
            fails++;
            $display("FAIL waiting_timeout dut%0d: waiting_bit=%b after %0d cycles, required 1", s, f_wait(s), n);
        end
    endtask

    task automatic send_bit(int s, logic b, int hold, int gap, output int tconf);
        wait_waiting(s);
        dbit[s] = b;
        conf[s] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tconf = cyc;
        for (int i = 0; i < hold; i++) begin
            if (i > 0) @(negedge clk);
            if (f_wait(s) !== 1'b0) wviol++;
        end
        conf[s] = 1'b0;
        dbit[s] = 1'($urandom_range(0, 1));
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(int s, logic [10:0] fr, int nb, int gap_last, output int tlast);
        int t = 0;
        for (int i = nb - 1; i >= 0; i--) begin
            send_bit(s, fr[i], 3, (i == 0) ? gap_last : 15, t);
        end
        tlast = t;
    endtask

    task automatic do_pop(int s, output logic v, output logic [W-1:0] d);
        v = f_valid(s);
        d = f_data(s);
        rdy[s] = 1'b1;
        @(negedge clk);
        rdy[s] = 1'b0;
    endtask

    task automatic drain(int s);
        logic v;
        logic [W-1:0] d;
        while (m_size(s) > 0) begin
            do_pop(s, v, d);
            m_pop(s);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            tests++;
            if ({f_wait(s), f_valid(s), f_data(s), f_fill(s), f_idx(s)} !== '0) begin
                fails++;
                $display("FAIL reset_outputs dut%0d: wait=%b valid=%b data=%h fill=%0d idx=%0d, required all 0",
                         s, f_wait(s), f_valid(s), f_data(s), f_fill(s), f_idx(s));
            end
            tests++;
            if (perr_cnt[s] !== 0 || ovf_cnt[s] !== 0) begin
                fails++;
                $display("FAIL reset_pulses dut%0d: parity_err=%0d overflow=%0d pulses, required 0", s, perr_cnt[s], ovf_cnt[s]);
            end
        end
        conf[0] = 1'b1;
        dbit[0] = 1'b1;
        @(negedge clk);
        conf[0] = 1'b0;
        rst[0]  = 1'b0;
        rst[1]  = 1'b0;
        @(negedge clk);
        tests++;
        if (f_idx(0) !== 4'd0 || f_wait(0) !== 1'b1) begin
            fails++;
            $display("FAIL reset_confirm_ignored: idx=%0d waiting=%b, required 0 and 1", f_idx(0), f_wait(0));
        end
    endtask

    task automatic test_basic();
        logic [10:0] fr;
        int tl;
        logic v;
        logic [W-1:0] d;
        fr = {1'b0, 10'b1011001110};
        wviol = 0;
        send_frame(0, fr, 10, 15, tl);
        m_frame(0, fr, 1'b0);
        tests++;
        if (vrise_cyc[0] - tl !== ST + 1) begin
            fails++;
            $display("FAIL basic_latency: valid rose %0d cycles after confirm, required %0d", vrise_cyc[0] - tl, ST + 1);
        end
        tests++;
        if (f_valid(0) !== 1'b1 || f_data(0) !== 10'h2CE) begin
            fails++;
            $display("FAIL basic_data: valid=%b data=%h, required 1 and 2ce", f_valid(0), f_data(0));
        end
        tests++;
        if (wviol !== 0 || f_wait(0) !== 1'b1) begin
            fails++;
            $display("FAIL basic_waiting: %0d cycles high while confirm held, idle waiting=%b; required 0 and 1", wviol, f_wait(0));
        end
        do_pop(0, v, d);
        tests++;
        if (d !== m_front(0) || f_fill(0) !== 3'd0 || f_data(0) !== 10'h2CE) begin
            fails++;
            $display("FAIL basic_pop: popped=%h fill=%0d held=%h, required %h, 0, 2ce", d, f_fill(0), f_data(0), m_front(0));
        end
        m_pop(0);
    endtask

    task automatic test_hold();
        logic [W-1:0] w;
        logic [10:0] fr;
        int t;
        w  = W'($urandom);
        fr = {1'b0, w};
        wviol = 0;
        send_bit(0, fr[9], 40, 0, t);
        tests++;
        if (f_idx(0) !== 4'd1 || wviol !== 0) begin
            fails++;
            $display("FAIL hold_single_bit: bit_index=%0d waiting_while_held=%0d, required 1 and 0", f_idx(0), wviol);
        end
        @(negedge clk);
        tests++;
        if (f_wait(0) !== 1'b1 || f_idx(0) !== 4'd1) begin
            fails++;
            $display("FAIL hold_release: waiting=%b idx=%0d after confirm fell, required 1 and 1", f_wait(0), f_idx(0));
        end
        for (int i = 8; i >= 0; i--) send_bit(0, fr[i], 3, 15, t);
        m_frame(0, fr, 1'b0);
        tests++;
        if (f_fill(0) !== 3'(m_size(0)) || f_data(0) !== w) begin
            fails++;
            $display("FAIL hold_word: fill=%0d data=%h, required %0d and %h", f_fill(0), f_data(0), m_size(0), w);
        end
        drain(0);
    endtask

    task automatic test_parity();
        int tl;
        int p0;
        p0 = perr_cnt[1];
        send_frame(1, {10'h2CE, 1'b0}, 11, 15, tl);
        m_frame(1, {10'h2CE, 1'b0}, 1'b0);
        tests++;
        if (f_fill(1) !== 3'd1 || f_data(1) !== 10'h2CE || perr_cnt[1] !== p0) begin
            fails++;
            $display("FAIL parity_good: fill=%0d data=%h perr_pulses=%0d, required 1, 2ce, %0d", f_fill(1), f_data(1), perr_cnt[1], p0);
        end
        send_frame(1, {10'h2CE, 1'b1}, 11, 15, tl);
        m_frame(1, {10'h2CE, 1'b1}, 1'b0);
        tests++;
        if (perr_cnt[1] !== p0 + 1 || f_fill(1) !== 3'd1) begin
            fails++;
            $display("FAIL parity_bad: perr_pulses=%0d fill=%0d, required %0d and 1", perr_cnt[1], f_fill(1), p0 + 1);
        end
        drain(1);
    endtask

    task automatic test_overflow();
        int tl;
        int o0;
        logic v;
        logic [W-1:0] d;
        logic [10:0] fr;
        o0 = ovf_cnt[0];
        for (int k = 1; k <= 5; k++) begin
            fr = {1'b0, 10'(k)};
            send_frame(0, fr, 10, 15, tl);
            m_frame(0, fr, 1'b0);
        end
        tests++;
        if (f_fill(0) !== 3'd4 || ovf_cnt[0] !== o0 + 1) begin
            fails++;
            $display("FAIL ovf_full: fill=%0d ovf_pulses=%0d, required 4 and %0d", f_fill(0), ovf_cnt[0], o0 + 1);
        end
        for (int k = 1; k <= 4; k++) begin
            do_pop(0, v, d);
            tests++;
            if (v !== 1'b1 || d !== 10'(k) || d !== m_front(0)) begin
                fails++;
                $display("FAIL ovf_pop%0d: valid=%b data=%h, required 1 and %h", k, v, d, 10'(k));
            end
            m_pop(0);
        end
        tests++;
        if (f_fill(0) !== 3'd0 || f_valid(0) !== 1'b0) begin
            fails++;
            $display("FAIL ovf_empty: fill=%0d valid=%b, required 0 and 0", f_fill(0), f_valid(0));
        end
        o0 = ovf_cnt[0];
        for (int k = 6; k <= 9; k++) begin
            fr = {1'b0, 10'(k)};
            send_frame(0, fr, 10, 15, tl);
            m_frame(0, fr, 1'b0);
        end
        fr = {1'b0, 10'd10};
        send_frame(0, fr, 10, 0, tl);
        while (cyc < tl + ST) @(negedge clk);
        rdy[0] = 1'b1;
        @(negedge clk);
        rdy[0] = 1'b0;
        m_frame(0, fr, 1'b1);
        repeat (5) @(negedge clk);
        tests++;
        if (f_fill(0) !== 3'd4 || ovf_cnt[0] !== o0 || ovf_cnt[0] !== exp_ovf[0]) begin
            fails++;
            $display("FAIL ovf_pop_push: fill=%0d ovf_pulses=%0d, required 4 and %0d", f_fill(0), ovf_cnt[0], o0);
        end
        for (int k = 7; k <= 10; k++) begin
            do_pop(0, v, d);
            tests++;
            if (v !== 1'b1 || d !== 10'(k) || d !== m_front(0)) begin
                fails++;
                $display("FAIL ovf_refill_pop%0d: valid=%b data=%h, required 1 and %h", k, v, d, 10'(k));
            end
            m_pop(0);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] w;
        logic [10:0] fr;
        int t;
        for (int k = 0; k < 2; k++) begin
            fr = {1'b0, W'($urandom)};
            send_frame(0, fr, 10, 15, t);
            m_frame(0, fr, 1'b0);
        end
        fr = {1'b0, W'($urandom)};
        for (int i = 9; i >= 4; i--) send_bit(0, fr[i], 3, (i == 4) ? 3 : 15, t);
        tests++;
        if (f_fill(0) !== 3'd2 || f_idx(0) !== 4'd5) begin
            fails++;
            $display("FAIL rstmid_before: fill=%0d idx=%0d, required 2 and 5", f_fill(0), f_idx(0));
        end
        rst[0] = 1'b1;
        conf[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        conf[0] = 1'b0;
        mq0.delete();
        tests++;
        if (f_fill(0) !== 3'd0 || f_valid(0) !== 1'b0 || f_idx(0) !== 4'd0) begin
            fails++;
            $display("FAIL rstmid_after: fill=%0d valid=%b idx=%0d, required 0, 0, 0", f_fill(0), f_valid(0), f_idx(0));
        end
        w  = W'($urandom);
        fr = {1'b0, w};
        send_frame(0, fr, 10, 15, t);
        m_frame(0, fr, 1'b0);
        tests++;
        if (f_fill(0) !== 3'd1 || f_data(0) !== w) begin
            fails++;
            $display("FAIL rstmid_frame: fill=%0d data=%h, required 1 and %h", f_fill(0), f_data(0), w);
        end
        drain(0);
    endtask

    task automatic test_random();
        logic [W-1:0] w;
        logic [10:0] fr;
        logic v;
        logic [W-1:0] d;
        bit bad;
        bit exp_v;
        int t;
        int npop;
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 10; n++) begin
                w   = W'($urandom);
                bad = (s == 1) && ($urandom_range(0, 3) == 0);
                fr  = (s == 0) ? {1'b0, w} : {w, (^w) ^ bad};
                send_frame(s, fr, (s == 0) ? 10 : 11, 15, t);
                m_frame(s, fr, 1'b0);
                tests++;
                if (f_fill(s) !== 3'(m_size(s))) begin
                    fails++;
                    $display("FAIL rand_fill dut%0d frame%0d: fill=%0d, required %0d", s, n, f_fill(s), m_size(s));
                end
                npop = $urandom_range(0, 2);
                for (int j = 0; j < npop; j++) begin
                    exp_v = (m_size(s) > 0);
                    do_pop(s, v, d);
                    tests++;
                    if (v !== exp_v || (exp_v && d !== m_front(s))) begin
                        fails++;
                        $display("FAIL rand_pop dut%0d frame%0d: valid=%b data=%h, required %b and %h", s, n, v, d, exp_v, m_front(s));
                    end
                    m_pop(s);
                end
            end
            tests++;
            if (perr_cnt[s] !== exp_perr[s] || ovf_cnt[s] !== exp_ovf[s]) begin
                fails++;
                $display("FAIL rand_pulses dut%0d: perr=%0d ovf=%0d, required %0d and %0d", s, perr_cnt[s], ovf_cnt[s], exp_perr[s], exp_ovf[s]);
            end
            drain(s);
            tests++;
            if (f_fill(s) !== 3'd0) begin
                fails++;
                $display("FAIL rand_drain dut%0d: fill=%0d, required 0", s, f_fill(s));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_parity();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instruction_rx.md
# instruction_rx

Parametrised serial instruction receiver for the servo controller front end. It collects a WIDTH-bit instruction one bit at a time from a manual data/confirm input pair, with a settle window after each confirm and an optional even-parity check. Completed words go into a DEPTH-entry first-word-fall-through queue, which the servo command decoder drains through a valid/ready handshake. The operator can therefore enter further instructions while earlier ones are still pending.

## Interface
- WIDTH, 10: instruction bits per word (2..32).
- SETTLE, 11: cycles the input is ignored after each accepted confirm (>=1).
- PARITY_EN, 1: when 1, a trailing even-parity bit follows the WIDTH data bits.
- DEPTH, 4: output queue entries (power of two, >=2).
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- data_bit  in  1  bit value presented by the operator; sampled with confirm.
- confirm_bit  in  1  level confirm; high accepts data_bit.
- waiting_bit  out  1  high while the receiver waits for the next confirm.
- bit_index  out  $clog2(WIDTH+2)  number of bits accepted in the current frame.
- instr_valid  out  1  queue not empty.
- instr_data  out  WIDTH  head-of-queue instruction.
- instr_ready  in  1  consumer pops the head when instr_valid && instr_ready.
- fill  out  $clog2(DEPTH+1)  entries held.
- parity_err  out  1  one-cycle pulse: frame discarded for a parity mismatch.
- overflow  out  1  one-cycle pulse: frame discarded because the queue was full.

## Operation
- FRAME = WIDTH + PARITY_EN bits. Data bits arrive MSB first.
- Reset: state RELEASE; shift register, bit_index, queue pointers and fill all 0. All outputs are 0: waiting_bit, instr_valid, instr_data, parity_err, overflow.
- RELEASE: wait for confirm_bit==0, then go to WAIT. This blocks a held confirm from being counted twice.
- WAIT: waiting_bit=1. On confirm_bit==1, capture data_bit and go to SETTLE.
- SETTLE: waiting_bit=0. The inputs are ignored; a counter runs 0..SETTLE-1.
  - On the last count, shift the captured bit into the shift register LSB and increment bit_index.
  - If bit_index reaches FRAME, go to CHECK; otherwise go to RELEASE.
- CHECK, one cycle:
  - If PARITY_EN and the XOR of all FRAME bits is 1: pulse parity_err; the frame is dropped.
  - Else if the queue is full and no pop occurs this cycle: pulse overflow; the frame is dropped.
  - Else push the WIDTH data bits.
  - In all cases, clear bit_index and the shift register, then go to RELEASE.
- Queue behaviour:
  - First-word fall-through. instr_data shows the head entry whenever instr_valid=1; when empty it holds its last value.
  - A pop and a push in the same cycle are both honoured: fill is unchanged and the pushed word goes behind the current head.
  - Pointers wrap modulo DEPTH.
  - A pop is ignored when the queue is empty. instr_ready is don't-care when instr_valid=0.
- The queue runs independently of the receiver FSM. The consumer may pop in any state.

## Timing
- Confirm sampled at edge T in WAIT: waiting_bit falls at T+1. The bit shifts and bit_index updates at T+SETTLE.
- If confirm is still high after SETTLE, the FSM stays in RELEASE. If confirm is already low, WAIT (waiting_bit=1) is entered at T+SETTLE+1 at the earliest.
- Last bit shifted at edge X: CHECK occupies cycle X..X+1. The push, parity_err and overflow register at X+1. instr_valid rises at X+1 if the queue was empty.
- Latency from the final confirm to instr_valid: SETTLE+1 cycles.
- Pop at edge P: the next entry appears on instr_data at P+1, and fill decrements at P+1.
- Reset mid-frame or mid-settle discards the partial frame and empties the queue. Confirm activity on the reset cycle is ignored.
- data_bit and confirm_bit are assumed already synchronised and debounced upstream. The settle window is only extra lockout.

## Test plan
- WIDTH=10, PARITY_EN=0, SETTLE=11:
  - Stimulus: enter bits 1011001110 with confirm pulses of 3 cycles separated by gaps of 15 cycles.
  - Required: instr_data=10'h2CE, instr_valid rising 12 cycles after the 10th confirm, waiting_bit high only in the gaps.
- Confirm held high for 40 cycles on one bit:
  - Required: bit_index advances by exactly 1.
  - Required: waiting_bit stays 0 until confirm falls.
- PARITY_EN=1:
  - Send 10'h2CE with parity bit 0 (the XOR of all 11 bits is 0): required push.
  - Resend with parity bit 1: required parity_err pulse, fill unchanged.
- DEPTH=4, instr_ready=0:
  - Enter 5 words 1..5. Required: fill=4, overflow pulse on the 5th, pops return 1,2,3,4.
  - Refill to 4. On the 5th CHECK cycle hold instr_ready=1. Required: push accepted, no overflow, fill stays 4.
- Reset asserted after 6 of 10 bits, with 2 words queued:
  - Required: fill=0 and instr_valid=0 next cycle.
  - Required: a full 10-bit frame entered afterwards produces exactly that word.
